// File: rtl/turn_sequencer.sv
// Checkers move sequencer: validates a selected piece, waits for the legal-move mask,
// then commits a move as single-square board writes (source, destination, capture).
module turn_sequencer (
   input  logic         clk,
   input  logic         rst,
   input  logic         sel_btn,
   input  logic [5:0]   cursor_loc,
   input  logic [191:0] serialized_board,
   input  logic [63:0]  legal_mask,
   input  logic         legal_valid,
   input  logic         jump_avail,
   output logic [5:0]   select_loc,
   output logic         sel_active,
   output logic         wr_en,
   output logic [5:0]   wr_addr,
   output logic [2:0]   wr_data,
   output logic         turn,
   output logic [7:0]   turn_count,
   output logic         busy,
   output logic [2:0]   dbg_state_o
);

   // IDLE encodes as 0 so the debug state reads 0 out of reset.
   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_LEGAL, S_PICKED, S_WR_SRC,
      S_WR_DST, S_WR_CAP, S_CHAIN_WAIT, S_NEXT_TURN
   } state_t;

   state_t      state_q;
   logic        sel_q;
   logic [5:0]  select_loc_q;
   logic        sel_active_q;
   logic        wr_en_q;
   logic [5:0]  wr_addr_q;
   logic [2:0]  wr_data_q;
   logic        turn_q;
   logic [7:0]  turn_count_q;
   logic        chaining_q;
   logic        entry_q;
   logic [5:0]  src_q;
   logic [5:0]  dst_q;
   logic        jump_q;
   logic        promo_q;
   logic [2:0]  piece_q;

   logic        sel_edge_d;
   logic [7:0]  cur_idx_d;
   logic [7:0]  sel_idx_d;
   logic [2:0]  cur_code_d;
   logic [2:0]  sel_code_d;
   logic        own_cur_d;
   logic [3:0]  drow_d;
   logic        jump_d;
   logic        promo_d;
   logic [2:0]  dst_code_d;
   logic [5:0]  cap_addr_d;

   function automatic logic owns(input logic [2:0] code, input logic side);
      return side ? (code == 3'd3 || code == 3'd4) : (code == 3'd1 || code == 3'd2);
   endfunction

   assign sel_edge_d = sel_btn & ~sel_q;
   assign cur_idx_d  = 8'(cursor_loc) * 8'd3;
   assign sel_idx_d  = 8'(select_loc_q) * 8'd3;
   assign cur_code_d = serialized_board[cur_idx_d +: 3];
   assign sel_code_d = serialized_board[sel_idx_d +: 3];
   assign own_cur_d  = owns(cur_code_d, turn_q);

   // A row distance of 2 in either direction marks a capture.
   assign drow_d     = {1'b0, cursor_loc[5:3]} - {1'b0, select_loc_q[5:3]};
   assign jump_d     = (drow_d == 4'd2) || (drow_d == 4'd14);

   assign promo_d    = (piece_q == 3'd1 && dst_q[5:3] == 3'd0) ||
                       (piece_q == 3'd3 && dst_q[5:3] == 3'd7);
   assign dst_code_d = promo_d ? piece_q + 3'd1 : piece_q;
   assign cap_addr_d = 6'(({1'b0, src_q} + {1'b0, dst_q}) >> 1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         sel_q        <= 1'b0;
         select_loc_q <= 6'd0;
         sel_active_q <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= 6'd0;
         wr_data_q    <= 3'd0;
         turn_q       <= 1'b0;
         turn_count_q <= 8'd0;
         chaining_q   <= 1'b0;
         entry_q      <= 1'b0;
         src_q        <= 6'd0;
         dst_q        <= 6'd0;
         jump_q       <= 1'b0;
         promo_q      <= 1'b0;
         piece_q      <= 3'd0;
      end else begin
         sel_q   <= sel_btn;
         wr_en_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (sel_edge_d && own_cur_d) begin
                  select_loc_q <= cursor_loc;
                  sel_active_q <= 1'b1;
                  entry_q      <= 1'b1;
                  state_q      <= S_WAIT_LEGAL;
               end
            end
            S_WAIT_LEGAL: begin
               if (entry_q) begin
                  entry_q <= 1'b0;
               end else if (legal_valid) begin
                  if (legal_mask == 64'd0) begin
                     sel_active_q <= 1'b0;
                     state_q      <= S_IDLE;
                  end else begin
                     state_q <= S_PICKED;
                  end
               end
            end
            S_PICKED: begin
               if (sel_edge_d) begin
                  if (cursor_loc == select_loc_q && !chaining_q) begin
                     sel_active_q <= 1'b0;
                     state_q      <= S_IDLE;
                  end else if (legal_mask[cursor_loc]) begin
                     dst_q     <= cursor_loc;
                     src_q     <= select_loc_q;
                     jump_q    <= jump_d;
                     piece_q   <= sel_code_d;
                     wr_en_q   <= 1'b1;
                     wr_addr_q <= select_loc_q;
                     wr_data_q <= 3'd0;
                     state_q   <= S_WR_SRC;
                  end else if (own_cur_d && !chaining_q) begin
                     select_loc_q <= cursor_loc;
                     entry_q      <= 1'b1;
                     state_q      <= S_WAIT_LEGAL;
                  end
               end
            end
            S_WR_SRC: begin
               wr_en_q   <= 1'b1;
               wr_addr_q <= dst_q;
               wr_data_q <= dst_code_d;
               promo_q   <= promo_d;
               state_q   <= S_WR_DST;
            end
            S_WR_DST: begin
               if (jump_q) begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= cap_addr_d;
                  wr_data_q <= 3'd0;
                  state_q   <= S_WR_CAP;
               end else begin
                  state_q <= S_NEXT_TURN;
               end
            end
            S_WR_CAP: begin
               // A promoting capture ends the turn; otherwise the piece may keep jumping.
               if (promo_q) begin
                  state_q <= S_NEXT_TURN;
               end else begin
                  select_loc_q <= dst_q;
                  chaining_q   <= 1'b1;
                  entry_q      <= 1'b1;
                  state_q      <= S_CHAIN_WAIT;
               end
            end
            S_CHAIN_WAIT: begin
               if (entry_q) begin
                  entry_q <= 1'b0;
               end else if (legal_valid) begin
                  state_q <= jump_avail ? S_PICKED : S_NEXT_TURN;
               end
            end
            S_NEXT_TURN: begin
               turn_q       <= ~turn_q;
               turn_count_q <= turn_count_q + 8'd1;
               sel_active_q <= 1'b0;
               chaining_q   <= 1'b0;
               state_q      <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign select_loc  = select_loc_q;
   assign sel_active  = sel_active_q;
   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign turn        = turn_q;
   assign turn_count  = turn_count_q;
   assign busy        = !(state_q == S_IDLE || state_q == S_PICKED);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer: directed game scenarios plus random single moves, with the
// board held here and every write predicted from checkers rules on row/column geometry.
module tb_turn_sequencer;

   logic         clk;
   logic         rst;
   logic         sel_btn;
   logic [5:0]   cursor_loc;
   logic [191:0] serialized_board;
   logic [63:0]  legal_mask;
   logic         legal_valid;
   logic         jump_avail;
   logic [5:0]   select_loc;
   logic         sel_active;
   logic         wr_en;
   logic [5:0]   wr_addr;
   logic [2:0]   wr_data;
   logic         turn;
   logic [7:0]   turn_count;
   logic         busy;
   logic [2:0]   dbg_state;

   logic [2:0]   brd [64];
   logic [8:0]   exp_q [$];
   logic         exp_turn;
   logic [7:0]   exp_count;
   int           checks;
   int           errors;

   turn_sequencer dut (
      .clk              (clk),
      .rst              (rst),
      .sel_btn          (sel_btn),
      .cursor_loc       (cursor_loc),
      .serialized_board (serialized_board),
      .legal_mask       (legal_mask),
      .legal_valid      (legal_valid),
      .jump_avail       (jump_avail),
      .select_loc       (select_loc),
      .sel_active       (sel_active),
      .wr_en            (wr_en),
      .wr_addr          (wr_addr),
      .wr_data          (wr_data),
      .turn             (turn),
      .turn_count       (turn_count),
      .busy             (busy),
      .dbg_state_o      (dbg_state)
   );

   // clock / board
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      serialized_board = '0;
      for (int i = 0; i < 64; i++) serialized_board[3*i +: 3] = brd[i];
   end

   // scoreboard primitive
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic clear_board();
      for (int i = 0; i < 64; i++) brd[i] = 3'd0;
   endtask

   task automatic press(input int loc);
      @(negedge clk);
      cursor_loc = 6'(loc);
      sel_btn    = 1'b1;
      @(negedge clk);
      sel_btn     = 1'b0;
      legal_valid = 1'b0;
   endtask

   task automatic give_legal(input logic [63:0] m, input logic j);
      @(negedge clk);
      legal_mask  = m;
      jump_avail  = j;
      legal_valid = 1'b1;
      @(negedge clk);
   endtask

   function automatic logic [63:0] bit_of(input int sq);
      logic [63:0] m;
      m = 64'd0;
      m[sq] = 1'b1;
      return m;
   endfunction

   // Predict the writes of a move from geometry, press the destination, then watch
   // every cycle of the commit for exactly the predicted writes.
   task automatic commit(input int src, input int dst, output bit chained);
      int rs, cs, rd, cd, mid, n;
      logic [2:0] code, nc;
      logic [8:0] e;
      bit jmp, promo;
      rs = src / 8; cs = src % 8; rd = dst / 8; cd = dst % 8;
      code  = brd[src];
      jmp   = (rd - rs == 2) || (rs - rd == 2);
      promo = (code == 3'd1 && rd == 0) || (code == 3'd3 && rd == 7);
      nc    = promo ? ((code == 3'd1) ? 3'd2 : 3'd4) : code;
      mid   = ((rs + rd) / 2) * 8 + (cs + cd) / 2;
      exp_q.push_back({6'(src), 3'd0});
      exp_q.push_back({6'(dst), nc});
      if (jmp) exp_q.push_back({6'(mid), 3'd0});
      n = jmp ? 3 : 2;
      press(dst);
      for (int k = 0; k <= n; k++) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wr", {wr_en, wr_addr, wr_data}, {1'b1, e});
         end else begin
            check("wr_idle", wr_en, 0);
         end
         @(negedge clk);
      end
      brd[src] = 3'd0;
      brd[dst] = nc;
      if (jmp) brd[mid] = 3'd0;
      chained = jmp && !promo;
      if (!chained) begin
         exp_turn  = ~exp_turn;
         exp_count = exp_count + 8'd1;
      end
      check("turn", turn, exp_turn);
      check("turn_count", turn_count, exp_count);
   endtask

   task automatic end_chain();
      give_legal(64'd0, 1'b0);
      @(negedge clk);
      exp_turn  = ~exp_turn;
      exp_count = exp_count + 8'd1;
      check("chain_end_turn", turn, exp_turn);
      check("chain_end_count", turn_count, exp_count);
      check("chain_end_sel", sel_active, 0);
   endtask

   task automatic rand_move();
      int src, dst, dr, dc, rs, cs, tdr, tdc, step, decoy;
      bit jmp, chained;
      logic [2:0] code;
      logic [63:0] m;
      clear_board();
      jmp  = ($urandom_range(0, 1) == 1);
      step = jmp ? 2 : 1;
      code = exp_turn ? 3'($urandom_range(3, 4)) : 3'($urandom_range(1, 2));
      src = 27; dr = step; dc = step;
      for (int t = 0; t < 50; t++) begin
         rs  = $urandom_range(0, 7);
         cs  = $urandom_range(0, 7);
         tdr = ($urandom_range(0, 1) == 1) ? step : -step;
         tdc = ($urandom_range(0, 1) == 1) ? step : -step;
         if (rs + tdr >= 0 && rs + tdr <= 7 && cs + tdc >= 0 && cs + tdc <= 7) begin
            src = rs * 8 + cs; dr = tdr; dc = tdc;
            break;
         end
      end
      dst = src + dr * 8 + dc;
      brd[src] = code;
      if (jmp) brd[src + (dr / 2) * 8 + dc / 2] = exp_turn ? 3'd1 : 3'd3;
      decoy = $urandom_range(0, 63);
      if (brd[decoy] == 3'd0) brd[decoy] = 3'($urandom_range(5, 7));
      press(src);
      check("rnd_sel_active", sel_active, 1);
      check("rnd_select_loc", select_loc, src);
      m = bit_of(dst) | {$urandom, $urandom};
      give_legal(m, jmp);
      commit(src, dst, chained);
      if (chained) begin
         check("rnd_chain_loc", select_loc, dst);
         check("rnd_chain_busy", busy, 1);
         end_chain();
      end
   endtask

   initial begin
      bit ch;
      logic [8:0] e;
      checks = 0; errors = 0;
      exp_turn = 1'b0; exp_count = 8'd0;
      rst = 1'b0; sel_btn = 1'b0; cursor_loc = 6'd0;
      legal_mask = 64'd0; legal_valid = 1'b0; jump_avail = 1'b0;
      clear_board();
      repeat (3) @(negedge clk);

      // reset state
      check("rst_select_loc", select_loc, 0);
      check("rst_sel_active", sel_active, 0);
      check("rst_wr", {wr_en, wr_addr, wr_data}, 0);
      check("rst_turn", turn, 0);
      check("rst_count", turn_count, 0);
      check("rst_busy", busy, 0);
      check("rst_state", dbg_state, 0);
      rst = 1'b1;

      // own-piece select and simple move 41 -> 32
      brd[41] = 3'd1;
      press(41);
      check("sel_loc", select_loc, 41);
      check("sel_active", sel_active, 1);
      check("wait_busy", busy, 1);
      give_legal(bit_of(32), 1'b0);
      check("picked_busy", busy, 0);
      commit(41, 32, ch);
      check("simple_sel_off", sel_active, 0);

      // black to move: red, odd-code and empty squares are not selectable
      brd[10] = 3'd6;
      press(32);
      check("foreign_sel", sel_active, 0);
      check("foreign_busy", busy, 0);
      press(10);
      check("odd_code_sel", sel_active, 0);
      press(20);
      check("empty_sel", sel_active, 0);

      // black man promotes on a simple move 50 -> 57
      brd[50] = 3'd3;
      press(50);
      give_legal(bit_of(57), 1'b0);
      commit(50, 57, ch);

      // red: empty mask, deselect, swap, then a two-jump chain
      brd[45] = 3'd1; brd[36] = 3'd3; brd[18] = 3'd3;
      press(45);
      give_legal(64'd0, 1'b0);
      check("empty_mask_sel", sel_active, 0);
      check("empty_mask_busy", busy, 0);
      check("empty_mask_turn", turn, exp_turn);
      press(45);
      give_legal(bit_of(27), 1'b1);
      press(45);
      check("deselect", sel_active, 0);
      press(45);
      give_legal(bit_of(27), 1'b1);
      press(32);
      check("swap_loc", select_loc, 32);
      check("swap_busy", busy, 1);
      give_legal(bit_of(24), 1'b0);
      press(45);
      check("swap_back_loc", select_loc, 45);
      give_legal(bit_of(27), 1'b1);
      commit(45, 27, ch);
      check("chain_flag", ch, 1);
      check("chain_loc", select_loc, 27);
      check("chain_wait_busy", busy, 1);
      give_legal(bit_of(9), 1'b1);
      check("chain_picked_busy", busy, 0);
      press(27);
      check("chain_no_deselect", sel_active, 1);
      check("chain_no_deselect_loc", select_loc, 27);
      press(32);
      check("chain_no_swap", select_loc, 27);
      press(20);
      check("chain_ignore_loc", select_loc, 27);
      check("chain_ignore_busy", busy, 0);
      commit(27, 9, ch);
      check("chain2_loc", select_loc, 9);
      end_chain();

      // black jump that promotes ends the turn without chaining
      clear_board();
      brd[43] = 3'd3; brd[52] = 3'd1;
      press(43);
      give_legal(bit_of(61), 1'b1);
      commit(43, 61, ch);
      check("promo_jump_nochain", ch, 0);
      check("promo_jump_sel", sel_active, 0);

      // random moves
      repeat (30) rand_move();

      // async reset while the destination write is on the bus
      clear_board();
      brd[19] = exp_turn ? 3'd3 : 3'd1;
      press(19);
      give_legal(bit_of(26), 1'b0);
      press(26);
      e = {6'd19, 3'd0};
      check("rst_mid_src", {wr_en, wr_addr, wr_data}, {1'b1, e});
      @(negedge clk);
      e = {6'd26, brd[19]};
      check("rst_mid_dst", {wr_en, wr_addr, wr_data}, {1'b1, e});
      #1 rst = 1'b0;
      #1;
      check("arst_wr", {wr_en, wr_addr, wr_data}, 0);
      check("arst_sel", {sel_active, select_loc}, 0);
      check("arst_turn", {turn, turn_count}, 0);
      check("arst_busy", busy, 0);
      exp_q.delete();
      exp_turn = 1'b0; exp_count = 8'd0;
      clear_board();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_wr", wr_en, 0);

      // turn counter wrap
      repeat (255) rand_move();
      check("count_255", turn_count, 8'd255);
      rand_move();
      check("count_wrap", turn_count, 8'd0);
      check("turn_after_wrap", turn, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
